// File: rtl/seqdet_pkg.sv
// Shared types and elaboration-time table builder for the parametrised Mealy
// serial-pattern detector.
package seqdet_pkg;

  localparam int MAX_N     = 32;
  localparam int SW_MAX    = $clog2(MAX_N);
  localparam int TBL_DEPTH = 2 * MAX_N;
  localparam int IDX_W     = $clog2(TBL_DEPTH);

  typedef struct packed {
    logic              hit;
    logic [SW_MAX-1:0] next;
  } seqdet_entry_t;

  // Entry for state s and input bit b lives at index {s, b}.
  typedef seqdet_entry_t [TBL_DEPTH-1:0] seqdet_table_t;

  // Bit i of the pattern in arrival order (i = 0 is received first).
  function automatic logic pat_bit(input int n, input logic [MAX_N-1:0] pat, input int i);
    logic [MAX_N-1:0] sh;
    sh = pat >> (n - 1 - i);
    return sh[0];
  endfunction

  // Length of the longest proper prefix of the first k pattern bits that is
  // also a suffix of them.
  function automatic int kmp_fail(input int n, input logic [MAX_N-1:0] pat, input int k);
    int best;
    bit ok;
    best = 0;
    for (int len = 1; len < k; len++) begin
      ok = 1'b1;
      for (int j = 0; j < len; j++) begin
        if (pat_bit(n, pat, j) != pat_bit(n, pat, k - len + j)) ok = 1'b0;
      end
      if (ok) best = len;
    end
    return best;
  endfunction

  function automatic seqdet_table_t build_table(input int n, input logic [MAX_N-1:0] pat,
                                                input bit overlap);
    seqdet_table_t tbl;
    int            cand;
    bit            found;
    tbl = '0;
    for (int s = 0; s < n; s++) begin
      for (int b = 0; b < 2; b++) begin
        cand  = s;
        found = 1'b0;
        // Walk the failure chain until the input bit extends some prefix.
        for (int iter = 0; iter <= MAX_N; iter++) begin
          if (!found) begin
            if (pat_bit(n, pat, cand) == b[0]) begin
              cand  = cand + 1;
              found = 1'b1;
            end else if (cand == 0) begin
              found = 1'b1;
            end else begin
              cand = kmp_fail(n, pat, cand);
            end
          end
        end
        tbl[IDX_W'(2 * s + b)].hit  = (cand == n);
        tbl[IDX_W'(2 * s + b)].next = SW_MAX'((cand == n) ? (overlap ? kmp_fail(n, pat, n) : 0)
                                                          : cand);
      end
    end
    return tbl;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and a synchronous clear that
// takes priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;
  logic [W:0]   sum;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    sum = {1'b0, q_q} + (W + 1)'(1);
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = sum[W] ? q_q : sum[W-1:0];
    end
  end

  // NOTE: state is updated with <= only, so all flops sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mealy_seq_detector_p.sv
// Parametrised Mealy serial-pattern detector: KMP-derived next-state/hit table,
// zero-latency match pulse, saturating match counter.
module mealy_seq_detector_p
  import seqdet_pkg::*;
#(
  parameter int           N       = 3,
  parameter logic [N-1:0] PATTERN = 3'b101,
  parameter bit           OVERLAP = 1'b1,
  parameter int           CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             in_valid,
  input  logic             clear,
  output logic             done,
  output logic             partial,
  output logic [CNT_W-1:0] match_cnt
);

  if (N < 2 || N > MAX_N) begin : g_bad_n
    $error("mealy_seq_detector_p: N must be in 2..32");
  end

  localparam int            SW    = $clog2(N);
  localparam seqdet_table_t TABLE = build_table(N, MAX_N'(PATTERN), OVERLAP);

  logic [SW-1:0]    cs_q, cs_d;
  logic             partial_q;
  logic [IDX_W-1:0] idx;
  seqdet_entry_t    entry;

  always_comb begin
    idx   = IDX_W'({cs_q, sin});
    entry = TABLE[idx];
    cs_d  = cs_q;
    done  = 1'b0;
    if (in_valid && !rst) begin
      cs_d = SW'(entry.next);
      done = entry.hit;
    end
  end

  // NOTE: reset is synchronous and active-high, so it is tested inside the clocked block only.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q      <= '0;
      partial_q <= 1'b0;
    end else begin
      cs_q      <= cs_d;
      partial_q <= (cs_d != '0);
    end
  end

  assign partial = partial_q;

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (done),
    .q   (match_cnt)
  );

endmodule

// File: tb/tb_mealy_seq_detector_p.sv
// Scoreboard bench: stimulus pushes hand-computed expectations per cycle, a
// negedge monitor pops and compares against the selected detector instance.
module tb_mealy_seq_detector_p;

  logic clk = 1'b0;
  logic rst, sin, in_valid, clear;

  always #5 clk = ~clk;

  logic       done_a, partial_a, done_b, partial_b, done_c, partial_c, done_d, partial_d;
  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic [1:0] cnt_d;

  // A: 101 overlapping; B: 101 non-overlapping; C: 1101; D: 101 with a 2-bit counter.
  mealy_seq_detector_p u_a (.clk(clk), .rst(rst), .sin(sin), .in_valid(in_valid), .clear(clear),
                            .done(done_a), .partial(partial_a), .match_cnt(cnt_a));
  mealy_seq_detector_p #(.OVERLAP(1'b0)) u_b (.clk(clk), .rst(rst), .sin(sin), .in_valid(in_valid),
                            .clear(clear), .done(done_b), .partial(partial_b), .match_cnt(cnt_b));
  mealy_seq_detector_p #(.N(4), .PATTERN(4'b1101)) u_c (.clk(clk), .rst(rst), .sin(sin),
                            .in_valid(in_valid), .clear(clear), .done(done_c), .partial(partial_c),
                            .match_cnt(cnt_c));
  mealy_seq_detector_p #(.CNT_W(2)) u_d (.clk(clk), .rst(rst), .sin(sin), .in_valid(in_valid),
                            .clear(clear), .done(done_d), .partial(partial_d), .match_cnt(cnt_d));

  typedef struct {
    string name;
    int    sel;
    bit    done;
    bit    partial;
    int    cnt;
  } exp_t;

  exp_t  exp_q[$];
  int    n_pass  = 0;
  int    n_total = 0;
  int    cur_sel = 0;
  string tname   = "";
  int    step_i  = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Monitor: outputs are valid every cycle, sampled on the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   ad, ap, ac;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      case (e.sel)
        0:       begin ad = int'(done_a); ap = int'(partial_a); ac = int'(cnt_a); end
        1:       begin ad = int'(done_b); ap = int'(partial_b); ac = int'(cnt_b); end
        2:       begin ad = int'(done_c); ap = int'(partial_c); ac = int'(cnt_c); end
        default: begin ad = int'(done_d); ap = int'(partial_d); ac = int'(cnt_d); end
      endcase
      check({e.name, ".done"},    ad, int'(e.done));
      check({e.name, ".partial"}, ap, int'(e.partial));
      check({e.name, ".cnt"},     ac, e.cnt);
    end
  end

  task automatic begin_test(input string name, input int sel);
    tname   = name;
    cur_sel = sel;
    step_i  = 0;
    rst = 1'b1; sin = 1'b0; in_valid = 1'b0; clear = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drive one cycle of inputs; expected values are what the monitor sees this cycle.
  task automatic step(input bit s, input bit v, input bit c, input bit r,
                      input bit ed, input bit ep, input int ec);
    exp_t e;
    sin = s; in_valid = v; clear = c; rst = r;
    step_i++;
    e.name = $sformatf("%s.%0d", tname, step_i);
    e.sel = cur_sel; e.done = ed; e.partial = ep; e.cnt = ec;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; sin = 1'b0; in_valid = 1'b0; clear = 1'b0;
    @(posedge clk); #1;

    //                sin v clr rst done part cnt
    begin_test("ovl", 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 0, 1, 1);
    step(1, 1, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1, 2);
    step(0, 1, 0, 0, 0, 1, 2);
    step(1, 1, 0, 0, 1, 1, 2);
    step(0, 0, 0, 0, 0, 1, 3);

    begin_test("novl", 1);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);

    begin_test("kmp1101", 2);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1);

    begin_test("gaps", 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1);

    begin_test("sat", 3);
    step(1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, 0, 0, 1, (k < 3) ? k : 3);
      step(1, 1, 0, 0, 1, 1, (k < 3) ? k : 3);
    end
    step(0, 1, 0, 0, 0, 1, 3);
    step(1, 1, 1, 0, 1, 1, 3);
    step(0, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1);

    begin_test("midrst", 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
